// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, with a
// single full-subtractor cell and a borrow flop. start/done handshake.
//
// Handshake: start is accepted on a rising edge only while the block is idle
// or showing done; a, b are captured on that edge. busy is high for exactly
// WIDTH cycles afterwards, then done pulses for one cycle with diff,
// borrow_out and ovf valid. Those result outputs hold until the next
// operation completes. start while busy is ignored.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  // Full-subtractor cell operating on the current LSBs and the stored borrow.
  logic             x_bit, y_bit, d_bit, br_next;
  logic [WIDTH-1:0] res_shift;

  assign x_bit     = sa_q[0];
  assign y_bit     = sb_q[0];
  assign d_bit     = x_bit ^ y_bit ^ br_q;
  assign br_next   = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
  assign res_shift = {d_bit, res_q[WIDTH-1:1]};

  // Next-state and datapath updates; every register holds by default.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          br_d     = 1'b0;
          cnt_d    = '0;
          sign_a_d = a[WIDTH-1];
          sign_b_d = b[WIDTH-1];
          state_d  = S_SHIFT;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_SHIFT: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        res_d = res_shift;
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        // The cycle handling the sign bit publishes the finished result.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = S_DONE;
          diff_d   = res_shift;
          borrow_d = br_next;
          ovf_d    = (sign_a_q ^ sign_b_q) & (res_shift[WIDTH-1] ^ sign_a_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy       = (state_q == S_SHIFT);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: cycle-level reference model plus directed
// vectors with literal expected results.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a_i),
    .b          (b_i),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Tracks remaining busy cycles and the result of the accepted operation.
  int           m_busy_left = 0;
  bit           m_done      = 0;
  logic [W-1:0] m_diff      = '0;
  bit           m_borrow    = 0;
  bit           m_ovf       = 0;
  logic [W-1:0] p_diff;
  bit           p_borrow;
  bit           p_ovf;
  bit           m_started   = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    m_started = 1;
    if (rst) begin
      m_busy_left = 0;
      m_done      = 0;
      m_diff      = '0;
      m_borrow    = 0;
      m_ovf       = 0;
      exp_q.delete();
    end else if (m_busy_left > 0) begin
      m_busy_left = m_busy_left - 1;
      if (m_busy_left == 0) begin
        m_done   = 1;
        m_diff   = p_diff;
        m_borrow = p_borrow;
        m_ovf    = p_ovf;
      end
    end else if (start) begin
      p_diff      = W'(a_i - b_i);
      p_borrow    = (a_i < b_i);
      p_ovf       = (a_i[W-1] != b_i[W-1]) && (p_diff[W-1] != a_i[W-1]);
      exp_q.push_back(p_diff);
      m_busy_left = W;
      m_done      = 0;
    end else begin
      m_done = 0;
    end
  end

  // ---------------- compare process ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      chk("busy", 32'(busy), 32'(m_busy_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("diff", 32'(diff), 32'(m_diff));
      chk("borrow_out", 32'(borrow_out), 32'(m_borrow));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("busy_and_done", 32'(busy & done), 32'd0);
      if (done === 1'b1) begin
        done_pulses = done_pulses + 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          chk("scoreboard_diff", 32'(diff), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start = 1'b1;
    a_i   = av;
    b_i   = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until done is seen; bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc = cyc + 1;
    end
    if (done !== 1'b1) chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_vec(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input bit eb, input bit eo);
    int cyc;
    do_start(av, bv);
    wait_done(cyc);
    chk("latency", 32'(cyc), 32'd8);
    chk("vec_diff", 32'(diff), 32'(ed));
    chk("vec_borrow", 32'(borrow_out), 32'(eb));
    chk("vec_ovf", 32'(ovf), 32'(eo));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int pulses0;
    rst   = 1'b1;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);

    // Basic, borrow and overflow vectors.
    run_vec(8'h05, 8'h03, 8'h02, 0, 0);
    run_vec(8'h03, 8'h05, 8'hFE, 1, 0);
    run_vec(8'h00, 8'h00, 8'h00, 0, 0);
    run_vec(8'h80, 8'h01, 8'h7F, 0, 1);
    run_vec(8'h7F, 8'hFF, 8'h80, 1, 1);
    idle(2);

    // start during SHIFT is ignored.
    pulses0 = done_pulses;
    do_start(8'h10, 8'h01);
    idle(2);
    do_start(8'hFF, 8'hFF);
    wait_done(cyc);
    chk("ignored_diff", 32'(diff), 32'h0F);
    idle(12);
    chk("ignored_pulses", 32'(done_pulses - pulses0), 32'd1);

    // Reset mid-operation: no done ever appears.
    do_start(8'h33, 8'h11);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    pulses0 = done_pulses;
    idle(15);
    chk("midrst_no_done", 32'(done_pulses - pulses0), 32'd0);
    run_vec(8'h0A, 8'h0A, 8'h00, 0, 0);
    idle(2);

    // Back-to-back: start held in the DONE cycle.
    do_start(8'h20, 8'h01);
    wait_done(cyc);
    chk("b2b_first_diff", 32'(diff), 32'h1F);
    start = 1'b1;
    a_i   = 8'h01;
    b_i   = 8'h02;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_again", 32'(busy), 32'd1);
    wait_done(cyc);
    chk("b2b_gap", 32'(cyc + 1), 32'd9);
    chk("b2b_diff", 32'(diff), 32'hFF);
    chk("b2b_borrow", 32'(borrow_out), 32'd1);
    chk("b2b_ovf", 32'(ovf), 32'd0);

    // A few random operations checked by the model alone.
    for (int i = 0; i < 6; i++) begin
      do_start(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      wait_done(cyc);
      idle($urandom_range(0, 2));
    end
    idle(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
